clk_div_monitor: RTL
====================

# clk_div_monitor

Frequency and duty-cycle monitor that sits directly downstream of the synchronous clock divider. Runs on the source clock `i_clk`, samples the divided clock `o_clk` as a synchronous data input, and measures every divided period (in `i_clk` cycles) and its high time. It declares lock after a run of periods matching the expected ratio, and flags a sticky error on loss of match or on a stalled divider.

## Interface
- `CNT_W`, default 8: width of the period/high counters and of the ratio input.
- `LOCK_CNT`, default 4: number of consecutive matching periods required for lock (range 1..15).

- `i_clk`  in  1  source clock, shared with the divider.
- `i_rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `i_en`  in  1  monitor enable. Low forces IDLE and clears `o_locked`, `o_err` and `o_ovf`.
- `i_div_clk`  in  1  divider output. Register-driven from `i_clk`, so it is sampled without a synchronizer.
- `i_exp_ratio`  in  CNT_W  expected divide ratio. Static while `i_en` is high.
- `o_period`  out  CNT_W  last measured period, in `i_clk` cycles.
- `o_high`  out  CNT_W  `i_clk` cycles during which `i_div_clk` was sampled high in the last period.
- `o_valid`  out  1  one-cycle pulse when `o_period` and `o_high` update.
- `o_locked`  out  1  LOCK_CNT consecutive periods equal to `i_exp_ratio`.
- `o_err`  out  1  sticky: mismatch while locked.
- `o_ovf`  out  1  sticky: no rising edge within 2^CNT_W−1 cycles.

## Operation
- A `prev` register holds the previous sample of `i_div_clk`.
- Edge event E: a rising `i_clk` edge at which `i_div_clk`=1 and `prev`=0.
- FSM states:
  - IDLE: entered on reset or when `i_en`=0. Goes to SYNC when `i_en`=1.
  - SYNC: waits for the first E. On E, loads `cnt`=1 and `hcnt`=1, then goes to MEAS. No `o_valid` is produced.
  - MEAS: on every non-E cycle, `cnt` increments and `hcnt` increments if `i_div_clk`=1.
- On E in MEAS:
  - `o_period`←`cnt`, `o_high`←`hcnt`, `o_valid` pulses.
  - `cnt` and `hcnt` reload to 1.
- Match logic, evaluated on each E in MEAS:
  - Match when `cnt`==`i_exp_ratio`. On match, the match counter increments and saturates at LOCK_CNT. `o_locked` sets when the counter reaches LOCK_CNT.
  - On mismatch: the match counter clears. If `o_locked` was 1, `o_err` sets and `o_locked` clears.
  - On mismatch while not locked: no error is raised.
- `i_exp_ratio` < 2 never matches, because a synchronous divider cannot produce a period below 2.
- Timeout: if `cnt` reaches 2^CNT_W−1 in MEAS without an E:
  - `o_ovf` sets, `o_locked` clears, the match counter clears.
  - FSM returns to SYNC. No `o_valid` is produced.
- Sticky flags clear only on `i_rst` or `i_en`=0.
- Arithmetic: counters are unsigned CNT_W bits. `cnt` cannot wrap because of the timeout. `hcnt` ≤ `cnt` always.

## Timing
- Reset values: `o_period`=0, `o_high`=0, `o_valid`=0, `o_locked`=0, `o_err`=0, `o_ovf`=0, `prev`=0. FSM is in IDLE with all counters 0.
- All outputs are registered. For an E at edge k, `o_valid`, `o_period`, `o_high` and any lock/err change are visible after edge k and hold for exactly the cycle k→k+1.
- `o_period` and `o_high` hold their values between pulses.
- First `o_valid` arrives on the second E after enable. `o_locked` rises with the LOCK_CNT-th matching `o_valid`.
- `i_en` falling takes effect at the next edge: IDLE is entered, flags clear, and any in-flight measurement is discarded. `o_period` and `o_high` keep their last values.
- Asynchronous `i_rst` mid-period clears everything immediately. After release, measurement restarts from SYNC (if `i_en`=1).
- If `i_div_clk` is high at enable, `prev` is still 0 and that cycle counts as an E (first E in SYNC). This is acceptable: the first period is discarded.
- Simultaneous E and timeout cannot occur, because the timeout is checked only on non-E cycles.

## Test plan
- Ratio-9 divider (e.g. high 4, low 5), `i_exp_ratio`=9, `i_en`=1 → `o_valid` every 9 cycles, `o_period`=9, `o_high`=4; `o_locked`=1 with the 4th pulse; `o_err`=0.
- Locked at ratio 9, then one period stretched to 10 → `o_period`=10, `o_locked`→0, `o_err`→1 on that pulse; `o_err` stays 1 after 9-cycle periods resume and relock.
- `i_div_clk` held at 0 after lock, CNT_W=8 → `o_ovf`=1 and `o_locked`=0 exactly 255 cycles after the last E; FSM in SYNC; no `o_valid`.
- Ratio 2 (1 high/1 low), `i_exp_ratio`=2 → `o_period`=2, `o_high`=1 every 2 cycles; lock after 4 pulses. With `i_exp_ratio`=1 → never locks, `o_err`=0.
- `i_rst` asserted asynchronously mid-period while locked → all outputs 0 immediately; after release, first `o_valid` on the second E, lock after 4 more matches.
- `i_en` dropped for 1 cycle while `o_err`=1 → `o_err`, `o_locked`, `o_ovf` cleared next cycle; measurement resumes from SYNC.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Measures the period and high time of a register-driven divided clock in source-clock cycles.
// It declares lock on a run of periods at the expected ratio and raises sticky error and stall flags.
module clk_div_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_div_clk,
  input  logic [CNT_W-1:0] i_exp_ratio,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_ovf
);

  typedef enum logic [1:0] {StIdle, StSync, StMeas} state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RatioMin = CNT_W'(2);
  localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic edge_e;
  logic match;

  assign edge_e = i_div_clk & ~prev_q;
  // A synchronous divider cannot produce a period below 2, so such ratios never match.
  assign match  = (cnt_q == i_exp_ratio) && (i_exp_ratio >= RatioMin);

  always_comb begin
    state_d  = state_q;
    prev_d   = i_div_clk;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    mcnt_d   = mcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = err_q;
    ovf_d    = ovf_q;

    if (!i_en) begin
      state_d  = StIdle;
      prev_d   = 1'b0;
      cnt_d    = '0;
      hcnt_d   = '0;
      mcnt_d   = '0;
      locked_d = 1'b0;
      err_d    = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Keep prev low so a divider already high at enable counts as the first edge.
          prev_d  = 1'b0;
          state_d = StSync;
        end
        StSync: begin
          if (edge_e) begin
            cnt_d   = CntOne;
            hcnt_d  = CntOne;
            state_d = StMeas;
          end
        end
        StMeas: begin
          if (edge_e) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            cnt_d    = CntOne;
            hcnt_d   = CntOne;
            if (match) begin
              if (mcnt_q < LockCnt) mcnt_d = mcnt_q + 4'd1;
              if (mcnt_q >= LockCnt - 4'd1) locked_d = 1'b1;
            end else begin
              mcnt_d = '0;
              if (locked_q) begin
                err_d    = 1'b1;
                locked_d = 1'b0;
              end
            end
          end else if (cnt_q == CntMax) begin
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = '0;
            cnt_d    = '0;
            hcnt_d   = '0;
            state_d  = StSync;
          end else begin
            cnt_d = cnt_q + CntOne;
            if (i_div_clk) hcnt_d = hcnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      mcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_locked = locked_q;
  assign o_err    = err_q;
  assign o_ovf    = ovf_q;

endmodule
